fft_frame_buffer: RTL

FFT_FRAME_BUFFER -- requirements
Module: fft_frame_buffer

---
 rtl/fft_frame_buffer_pkg.sv | 21 ++
 rtl/fft_frame_buffer_window_mul.sv | 19 +
 rtl/fft_frame_buffer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fft_frame_buffer_pkg.sv
// Shared types and constants for the 16-sample FFT frame buffer.
// WIN_COEF is the periodic 16-point Hann window in Q1.23. The unity peak saturates to 24'h7FFFFF.
package fft_pkg;

  typedef logic signed [23:0] sample_t;

  localparam int unsigned FRAME_LEN = 16;

  localparam sample_t WIN_COEF [FRAME_LEN] = '{
    24'sd0,       24'sd319272,  24'sd1228483, 24'sd2589213,
    24'sd4194304, 24'sd5799395, 24'sd7160125, 24'sd8069336,
    24'sd8388607, 24'sd8069336, 24'sd7160125, 24'sd5799395,
    24'sd4194304, 24'sd2589213, 24'sd1228483, 24'sd319272
  };

  typedef enum logic {
    FILL,
    FULL
  } state_e;

endpackage

// File: rtl/fft_frame_buffer_window_mul.sv
// Signed Q1.23 window multiply: (sample * COEF) >>> 23, truncated toward -inf.
// The module is compiled only when FFT_FRAME_WINDOW_EN is defined.
`ifdef FFT_FRAME_WINDOW_EN
module fft_window_mul
  import fft_pkg::*;
#(
  parameter sample_t COEF = '0
) (
  input  sample_t sample_i,
  output sample_t product_o
);

  logic signed [47:0] prod;

  assign prod      = 48'(sample_i) * 48'(COEF);
  assign product_o = sample_t'(prod >>> 23);

endmodule
`endif

// File: rtl/fft_frame_buffer.sv
// Collects 16 audio samples into a fill bank and hands complete frames to a hold bank.
// Optional per-sample Hann windowing on transfer is enabled by FFT_FRAME_WINDOW_EN.
module fft_frame_buffer
  import fft_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        sample_valid,
  input  logic [23:0] sample_data,
  input  logic        frame_ready,
  output logic        frame_valid,
  output logic [23:0] s0,
  output logic [23:0] s1,
  output logic [23:0] s2,
  output logic [23:0] s3,
  output logic [23:0] s4,
  output logic [23:0] s5,
  output logic [23:0] s6,
  output logic [23:0] s7,
  output logic [23:0] s8,
  output logic [23:0] s9,
  output logic [23:0] s10,
  output logic [23:0] s11,
  output logic [23:0] s12,
  output logic [23:0] s13,
  output logic [23:0] s14,
  output logic [23:0] s15,
  output logic        overflow
);

  state_e     state_q, state_d;
  logic [3:0] wr_idx_q, wr_idx_d;
  sample_t    bank_q [FRAME_LEN];
  sample_t    bank_d [FRAME_LEN];
  sample_t    hold_q [FRAME_LEN];
  sample_t    hold_d [FRAME_LEN];
  sample_t    hold_src [FRAME_LEN];
  logic       frame_valid_q, frame_valid_d;
  logic       overflow_q, overflow_d;
  logic       hold_free;

`ifdef FFT_FRAME_WINDOW_EN
  for (genvar k = 0; k < int'(FRAME_LEN); k++) begin : g_win
    fft_window_mul #(
      .COEF(WIN_COEF[k])
    ) u_win (
      .sample_i (bank_q[k]),
      .product_o(hold_src[k])
    );
  end
`else
  always_comb hold_src = bank_q;
`endif

  assign hold_free = !frame_valid_q || frame_ready;

  always_comb begin
    state_d       = state_q;
    wr_idx_d      = wr_idx_q;
    bank_d        = bank_q;
    hold_d        = hold_q;
    frame_valid_d = frame_valid_q && !frame_ready;
    overflow_d    = overflow_q;

    case (state_q)
      FILL: begin
        if (sample_valid) begin
          bank_d[wr_idx_q] = sample_t'(sample_data);
          wr_idx_d         = wr_idx_q + 4'd1;
          if (wr_idx_q == 4'd15) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (hold_free) begin
          // hold_src comes from bank_q, so the copy sees the pre-write contents
          hold_d        = hold_src;
          frame_valid_d = 1'b1;
          state_d       = FILL;
          if (sample_valid) begin
            bank_d[0] = sample_t'(sample_data);
            wr_idx_d  = 4'd1;
          end
        end else if (sample_valid) begin
          overflow_d = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= FILL;
      wr_idx_q      <= '0;
      bank_q        <= '{default: '0};
      hold_q        <= '{default: '0};
      frame_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_idx_q      <= wr_idx_d;
      bank_q        <= bank_d;
      hold_q        <= hold_d;
      frame_valid_q <= frame_valid_d;
      overflow_q    <= overflow_d;
    end
  end

  assign frame_valid = frame_valid_q;
  assign overflow    = overflow_q;

  assign s0  = hold_q[0];
  assign s1  = hold_q[1];
  assign s2  = hold_q[2];
  assign s3  = hold_q[3];
  assign s4  = hold_q[4];
  assign s5  = hold_q[5];
  assign s6  = hold_q[6];
  assign s7  = hold_q[7];
  assign s8  = hold_q[8];
  assign s9  = hold_q[9];
  assign s10 = hold_q[10];
  assign s11 = hold_q[11];
  assign s12 = hold_q[12];
  assign s13 = hold_q[13];
  assign s14 = hold_q[14];
  assign s15 = hold_q[15];

endmodule
